// File: rtl/pc_unit.sv
// Fetch program counter with a one-entry stalled-redirect buffer and an optional return-address stack.
// Define PC_UNIT_RAS_EN to build the RAS; without it the RAS ports are inert and the stack always reads as empty.
module pc_unit_wp_hit (
  input  logic       we_i,
  input  logic [3:0] ws_i,
  output logic       hit_o
);
  assign hit_o = we_i & (ws_i == 4'hF);
endmodule

module pc_unit #(
  parameter int                ADDR_W    = 32,
  parameter int                NUM_WP    = 2,
  parameter int                RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                           clk,
  input  logic                           nreset,
  input  logic                           stall,
  input  logic                           cond_go,
  input  logic                           br_valid,
  input  logic [ADDR_W-1:0]              br_target,
  input  logic [NUM_WP-1:0]              wp_we,
  input  logic [NUM_WP-1:0][3:0]         wp_ws,
  input  logic [NUM_WP-1:0][ADDR_W-1:0]  wp_wd,
  input  logic                           ras_push,
  input  logic [ADDR_W-1:0]              ras_push_addr,
  input  logic                           ras_pop,
  output logic [ADDR_W-1:0]              pc,
  output logic [ADDR_W-1:0]              pc_plus4,
  output logic [ADDR_W-1:0]              pc_plus8,
  output logic [ADDR_W-1:0]              pc_plus12,
  output logic                           redirect_pending,
  output logic [ADDR_W-1:0]              ras_top,
  output logic                           ras_empty,
  output logic                           ras_full
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;

  assign pc               = pc_q;
  assign pc_plus4         = pc_q + ADDR_W'(4);
  assign pc_plus8         = pc_q + ADDR_W'(8);
  assign pc_plus12        = pc_q + ADDR_W'(12);
  assign redirect_pending = pend_q;

  // r15 write detection per write port
  logic [NUM_WP-1:0] wp_hit;
  for (genvar i = 0; i < NUM_WP; i++) begin : g_wp
    pc_unit_wp_hit u_hit (.we_i(wp_we[i]), .ws_i(wp_ws[i]), .hit_o(wp_hit[i]));
  end

  logic              wp_any;
  logic [ADDR_W-1:0] wp_tgt;
  always_comb begin
    wp_any = 1'b0;
    wp_tgt = '0;
    for (int i = NUM_WP - 1; i >= 0; i--) begin
      if (wp_hit[i]) begin
        wp_any = 1'b1;
        wp_tgt = wp_wd[i];
      end
    end
  end

`ifdef PC_UNIT_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [RAS_DEPTH-1:0][ADDR_W-1:0] ras_mem_q, ras_mem_d;
  logic [PTR_W-1:0]                 ras_ptr_q, ras_ptr_d;
  logic [CNT_W-1:0]                 ras_cnt_q, ras_cnt_d;

  assign ras_empty = (ras_cnt_q == '0);
  assign ras_full  = (ras_cnt_q == CNT_W'(RAS_DEPTH));
  assign ras_top   = ras_empty ? '0 : ras_mem_q[ras_ptr_q];

  // Pointer wraps naturally since RAS_DEPTH is a power of two
  always_comb begin
    ras_mem_d = ras_mem_q;
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    if (!stall && cond_go) begin
      if (ras_push && ras_pop && !ras_empty) begin
        ras_mem_d[ras_ptr_q] = ras_push_addr;
      end else if (ras_push) begin
        ras_ptr_d            = ras_ptr_q + PTR_W'(1);
        ras_mem_d[ras_ptr_d] = ras_push_addr;
        if (!ras_full) ras_cnt_d = ras_cnt_q + CNT_W'(1);
      end else if (ras_pop && !ras_empty) begin
        ras_ptr_d = ras_ptr_q - PTR_W'(1);
        ras_cnt_d = ras_cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      ras_mem_q <= '0;
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
    end else begin
      ras_mem_q <= ras_mem_d;
      ras_ptr_q <= ras_ptr_d;
      ras_cnt_q <= ras_cnt_d;
    end
  end
`else
  logic ras_unused;
  assign ras_unused = ras_push ^ (^ras_push_addr);
  assign ras_top    = '0;
  assign ras_empty  = 1'b1;
  assign ras_full   = 1'b0;
`endif

  logic              cand_vld;
  logic [ADDR_W-1:0] cand_tgt;
  always_comb begin
    cand_vld = 1'b0;
    cand_tgt = '0;
    if (cond_go) begin
      if (br_valid) begin
        cand_vld = 1'b1;
        cand_tgt = br_target;
      end else if (wp_any) begin
        cand_vld = 1'b1;
        cand_tgt = wp_tgt;
      end else if (ras_pop && !ras_empty) begin
        cand_vld = 1'b1;
        cand_tgt = ras_top;
      end
    end
  end

  // A buffered redirect always beats whatever arrives in its release cycle
  always_comb begin
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    if (stall) begin
      if (cand_vld && !pend_q) begin
        pend_d     = 1'b1;
        pend_tgt_d = cand_tgt;
      end
    end else if (pend_q) begin
      pc_d   = pend_tgt_q;
      pend_d = 1'b0;
    end else begin
      pc_d = cand_vld ? cand_tgt : pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      pc_q       <= RESET_PC;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a queue-based reference model predicts each cycle's outputs,
// a negedge monitor compares them, and a few directed scenarios also check fixed constants.
module tb_pc_unit;
  localparam int AW = 32;
  localparam int NW = 2;
  localparam int RD = 4;
`ifdef PC_UNIT_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic nreset, stall, cond_go, br_valid, ras_push, ras_pop;
  logic [AW-1:0] br_target, ras_push_addr;
  logic [NW-1:0] wp_we;
  logic [NW-1:0][3:0] wp_ws;
  logic [NW-1:0][AW-1:0] wp_wd;
  logic [AW-1:0] pc, pc_plus4, pc_plus8, pc_plus12, ras_top;
  logic redirect_pending, ras_empty, ras_full;

  pc_unit #(.ADDR_W(AW), .NUM_WP(NW), .RAS_DEPTH(RD), .RESET_PC('0)) dut (
    .clk(clk), .nreset(nreset), .stall(stall), .cond_go(cond_go),
    .br_valid(br_valid), .br_target(br_target),
    .wp_we(wp_we), .wp_ws(wp_ws), .wp_wd(wp_wd),
    .ras_push(ras_push), .ras_push_addr(ras_push_addr), .ras_pop(ras_pop),
    .pc(pc), .pc_plus4(pc_plus4), .pc_plus8(pc_plus8), .pc_plus12(pc_plus12),
    .redirect_pending(redirect_pending), .ras_top(ras_top),
    .ras_empty(ras_empty), .ras_full(ras_full));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic          pend;
    logic [AW-1:0] top;
    logic          empty;
    logic          full;
  } exp_t;

  exp_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  // Reference model: stack of return addresses as a queue, newest at the back
  logic [AW-1:0] m_pc;
  logic          m_pend;
  logic [AW-1:0] m_tgt;
  logic [AW-1:0] m_stk[$];

  task automatic model_push();
    bit have;
    logic [AW-1:0] t;
    exp_t e;
    have = 0;
    t = '0;
    if (!nreset) begin
      m_pc = '0; m_pend = 0; m_tgt = '0; m_stk.delete();
    end else begin
      if (cond_go) begin
        if (br_valid) begin have = 1; t = br_target; end
        else begin
          for (int i = 0; i < NW; i++)
            if (!have && wp_we[i] && wp_ws[i] == 4'hF) begin have = 1; t = wp_wd[i]; end
          if (!have && RAS_EN && ras_pop && m_stk.size() > 0) begin have = 1; t = m_stk[$]; end
        end
      end
      if (stall) begin
        if (have && !m_pend) begin m_pend = 1; m_tgt = t; end
      end else begin
        if (m_pend) begin m_pc = m_tgt; m_pend = 0; end
        else m_pc = have ? t : m_pc + 4;
        if (RAS_EN && cond_go) begin
          if (ras_push && ras_pop && m_stk.size() > 0) m_stk[m_stk.size()-1] = ras_push_addr;
          else if (ras_push) begin
            m_stk.push_back(ras_push_addr);
            if (m_stk.size() > RD) void'(m_stk.pop_front());
          end else if (ras_pop && m_stk.size() > 0) void'(m_stk.pop_back());
        end
      end
    end
    e.pc = m_pc; e.pend = m_pend;
    e.top = (m_stk.size() > 0) ? m_stk[$] : '0;
    e.empty = (m_stk.size() == 0);
    e.full = (m_stk.size() == RD);
    exp_q.push_back(e);
  endtask

  task automatic step();
    model_push();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    nreset = 1; stall = 0; cond_go = 1; br_valid = 0; br_target = '0;
    wp_we = '0; wp_ws = '0; wp_wd = '0;
    ras_push = 0; ras_push_addr = '0; ras_pop = 0;
  endtask

  task automatic br(input logic [AW-1:0] t);
    idle(); br_valid = 1; br_target = t; step();
  endtask

  task automatic push(input logic [AW-1:0] a);
    idle(); ras_push = 1; ras_push_addr = a; step();
  endtask

  task automatic pop();
    idle(); ras_pop = 1; step();
  endtask

  // Monitor: every negedge after the first edge compares one predicted cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc", pc, e.pc);
        chk("pc_plus4", pc_plus4, e.pc + 4);
        chk("pc_plus8", pc_plus8, e.pc + 8);
        chk("pc_plus12", pc_plus12, e.pc + 12);
        chk("pending", AW'(redirect_pending), AW'(e.pend));
        chk("ras_top", ras_top, e.top);
        chk("ras_flags", AW'({ras_empty, ras_full}), AW'({e.empty, e.full}));
      end
    end
  end

  initial begin
    logic [AW-1:0] p;
    idle(); nreset = 0;
    step(); step();
    chk("reset_pc", pc, 32'h0);
    chk("reset_empty", AW'(ras_empty), AW'(1));
    idle();
    step(); chk("free1", pc, 32'h4);
    step(); chk("free2", pc, 32'h8); chk("plus8_at_8", pc_plus8, 32'h10);
    step(); chk("free3", pc, 32'hC);

    br(32'h100);
    idle(); br_valid = 1; br_target = 32'h2000; wp_we = 2'b01; wp_ws[0] = 4'hF; wp_wd[0] = 32'h3000;
    step(); chk("br_over_wp", pc, 32'h2000);
    br(32'h100);
    idle(); cond_go = 0; br_valid = 1; br_target = 32'h2000; wp_we = 2'b01; wp_ws[0] = 4'hF; wp_wd[0] = 32'h3000;
    step(); chk("cond_fail", pc, 32'h104);

    idle(); wp_we = 2'b11; wp_ws[0] = 4'h3; wp_wd[0] = 32'h111; wp_ws[1] = 4'hF; wp_wd[1] = 32'h400;
    step(); chk("wp1_r15", pc, 32'h400);
    idle(); wp_we = 2'b11; wp_ws[0] = 4'hF; wp_wd[0] = 32'h500; wp_ws[1] = 4'hF; wp_wd[1] = 32'h600;
    step(); chk("wp_lowest", pc, 32'h500);

    br(32'h40);
    idle(); stall = 1; br_valid = 1; br_target = 32'h800; step();
    idle(); stall = 1; br_valid = 1; br_target = 32'h900; step();
    chk("stall_hold", pc, 32'h40);
    chk("stall_pend", AW'(redirect_pending), AW'(1));
    br(32'hA00);
    chk("oldest_wins", pc, 32'h800);
    chk("pend_clear", AW'(redirect_pending), AW'(0));
    idle(); step(); chk("after_pend", pc, 32'h804);

    idle(); stall = 1; br_valid = 1; br_target = 32'h123; step();
    idle(); nreset = 0; step();
    chk("rst_pend_pc", pc, 32'h0);
    chk("rst_pend", AW'(redirect_pending), AW'(0));
    idle(); step();

    push(32'h10); push(32'h20); push(32'h30); push(32'h40); push(32'h50);
`ifdef PC_UNIT_RAS_EN
    chk("ras_full", AW'(ras_full), AW'(1));
    pop(); chk("pop1", pc, 32'h50);
    pop(); chk("pop2", pc, 32'h40);
    pop(); chk("pop3", pc, 32'h30);
    pop(); chk("pop4", pc, 32'h20);
    chk("ras_empty_after", AW'(ras_empty), AW'(1));
    p = pc; pop(); chk("pop_empty", pc, p + 32'h4);
    push(32'h10); push(32'h20);
    idle(); ras_push = 1; ras_pop = 1; ras_push_addr = 32'h99; step();
    chk("pushpop_pc", pc, 32'h20);
    chk("pushpop_top", ras_top, 32'h99);
`else
    chk("noras_empty", AW'(ras_empty), AW'(1));
    p = pc; pop(); chk("noras_pop", pc, p + 32'h4);
    chk("noras_top", ras_top, 32'h0);
`endif

    // Random phase
    for (int c = 0; c < 600; c++) begin
      idle();
      nreset   = ($urandom_range(0, 49) != 0);
      stall    = ($urandom_range(0, 3) == 0);
      cond_go  = ($urandom_range(0, 4) != 0);
      br_valid = ($urandom_range(0, 6) == 0);
      br_target = $urandom;
      for (int i = 0; i < NW; i++) begin
        wp_we[i] = $urandom_range(0, 1);
        wp_ws[i] = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
        wp_wd[i] = $urandom;
      end
      ras_push = ($urandom_range(0, 3) == 0);
      ras_push_addr = $urandom;
      ras_pop  = ($urandom_range(0, 2) == 0);
      step();
    end

    idle();
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    @(negedge clk); #1;
    if (exp_q.size() > 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised next-generation program-counter unit for the ARM32 core.
- Holds the fetch PC and selects the next PC from four sources: a stalled-redirect buffer, taken branches, any of NUM_WP register-file write ports targeting r15, and a return-address stack (RAS).
- Adds stall handling with a one-entry pending-redirect buffer, so redirects arriving while stalled are never lost.
- Sits between the decode/execute stages and instruction fetch.

Parameters:
- ADDR_W, 32, PC width in bits; all PC arithmetic is modulo 2^ADDR_W.
- NUM_WP, 2, number of register-file write ports monitored for r15 writes.
- RAS_DEPTH, 4, return-address stack entries; must be a power of two and at least 2.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock
- nreset  in  1  reset
- stall  in  1  hold PC and capture redirects into the pending buffer
- cond_go  in  1  condition pass for the current instruction; gates every redirect source
- br_valid  in  1  taken-branch request (B/BL/BX)
- br_target  in  ADDR_W  branch target
- wp_we  in  NUM_WP  per-port write enable
- wp_ws  in  4*NUM_WP  per-port register select; port i uses bits [4i+3:4i]
- wp_wd  in  ADDR_W*NUM_WP  per-port write data; port i uses slice i
- ras_push  in  1  call (BL) qualified; push ras_push_addr
- ras_push_addr  in  ADDR_W  return address to push
- ras_pop  in  1  predicted return; use the RAS top as the next PC
- pc  out  ADDR_W  current fetch PC
- pc_plus4  out  ADDR_W  pc+4, combinational
- pc_plus8  out  ADDR_W  pc+8, combinational
- pc_plus12  out  ADDR_W  pc+12, combinational
- redirect_pending  out  1  pending buffer is occupied
- ras_top  out  ADDR_W  top-of-stack value; 0 when empty
- ras_empty  out  1  stack count is 0
- ras_full  out  1  stack count equals RAS_DEPTH

Behaviour:
- Reset is synchronous, active-low nreset, on clock clk.
- Reset values: pc=RESET_PC, pending buffer clear, redirect_pending=0, RAS count=0, RAS pointer=0, ras_empty=1, ras_full=0, ras_top=0.
  - Reset asserted mid-stall or mid-pending discards all pending and RAS state.
- Candidate redirect, in priority order; each requires cond_go=1:
  - (1) br_valid → br_target.
  - (2) lowest-index port i with wp_we[i]=1 and wp_ws[i]=4'hF → wp_wd slice i.
  - (3) ras_pop with ras_empty=0 → ras_top.
- Cycle with stall=0 and redirect_pending=1:
  - pc <= pending target; pending cleared.
  - All current-cycle redirect inputs are ignored. RAS push/pop still apply.
- Cycle with stall=0 and redirect_pending=0:
  - pc <= candidate redirect if one exists, else pc_plus4.
  - One-cycle latency: the new pc is visible the cycle after the request.
- Cycle with stall=1:
  - pc holds.
  - If a candidate exists and redirect_pending=0, latch its target and set redirect_pending.
  - If redirect_pending=1 already, the candidate is dropped; the oldest redirect wins.
  - RAS push/pop are ignored while stalled; the requester re-presents them.
- RAS operation is a circular buffer with a pointer and a count; only applied when stall=0 and cond_go=1.
  - Push only: write the entry at pointer+1, advance the pointer, count = min(count+1, RAS_DEPTH). When full, the oldest entry is silently overwritten.
  - Pop only with count>0: pointer-1, count-1.
  - Pop on empty: no state change and no redirect; falls through to pc_plus4.
  - Push and pop together:
    - count>0: top entry replaced in place with ras_push_addr; count unchanged.
    - count=0: behaves as push only.
- Pointer arithmetic wraps modulo RAS_DEPTH.
- ras_top is a combinational read of the entry at the pointer.

Optional Feature:
- Macro: PC_UNIT_RAS_EN.
- Defined: RAS implemented exactly as described above.
- Undefined: no RAS storage. ras_push and ras_pop are ignored, ras_top=0, ras_empty=1, ras_full=0, and priority source (3) never fires.

Test Plan:
- Reset, then 3 free cycles with no requests → pc = 0, 4, 8, 12; pc_plus8 = 16 when pc = 8.
- At pc=0x100, drive br_valid=1, br_target=0x2000, cond_go=1 together with wp0 writing r15 = 0x3000 → next pc = 0x2000. Repeat with cond_go=0 → next pc = 0x104.
- Drive wp0 we=1, ws=4'h3 and wp1 we=1, ws=4'hF, wd=0x400 → next pc = 0x400. Drive both ports writing r15 (0x500 on port 0, 0x600 on port 1) → next pc = 0x500.
- stall=1 at pc=0x40:
  - branch to 0x800 in cycle 1, then branch to 0x900 in cycle 2 → pc holds 0x40 and redirect_pending=1.
  - Release stall with br_valid to 0xA00 → next pc = 0x800, then 0x804.
- With RAS_DEPTH=4, push 0x10, 0x20, 0x30, 0x40, 0x50 → ras_full=1.
  - Pop 4 times → next pcs 0x50, 0x40, 0x30, 0x20; ras_empty=1.
  - A 5th pop → pc increments by 4.
- Push and pop together with top=0x20 → next pc = 0x20, new top = push value, count unchanged. With PC_UNIT_RAS_EN undefined → ras_empty stays 1 and pops give pc+4.
